// File: rtl/uart_led_pkg.sv
// ---------------------------------------------------------------------------
// uart_led_pkg
// Shared constants for the multi-channel UART LED controller:
//   - frame marker bytes (first header, second header, trailer)
//   - parser state encoding and the parser state type
//   - a helper that tells whether the parser is inside a frame body,
//     which is where the inter-byte timeout applies
// ---------------------------------------------------------------------------
package uart_led_pkg;

  localparam logic [7:0] HDR1 = 8'h55;
  localparam logic [7:0] HDR2 = 8'hA5;
  localparam logic [7:0] TAIL = 8'hF0;

  localparam logic [3:0] ST_IDLE = 4'd0;
  localparam logic [3:0] ST_HDR2 = 4'd1;
  localparam logic [3:0] ST_CH   = 4'd2;
  localparam logic [3:0] ST_T3   = 4'd3;
  localparam logic [3:0] ST_T2   = 4'd4;
  localparam logic [3:0] ST_T1   = 4'd5;
  localparam logic [3:0] ST_T0   = 4'd6;
  localparam logic [3:0] ST_PAT  = 4'd7;
  localparam logic [3:0] ST_CSUM = 4'd8;
  localparam logic [3:0] ST_TAIL = 4'd9;

  typedef enum logic [3:0] {
    S_IDLE = ST_IDLE,
    S_HDR2 = ST_HDR2,
    S_CH   = ST_CH,
    S_T3   = ST_T3,
    S_T2   = ST_T2,
    S_T1   = ST_T1,
    S_T0   = ST_T0,
    S_PAT  = ST_PAT,
    S_CSUM = ST_CSUM,
    S_TAIL = ST_TAIL
  } parser_state_t;

  // The idle timeout only guards the part of a frame after both header bytes.
  function automatic logic in_frame_body(input parser_state_t s);
    return !((s == S_IDLE) || (s == S_HDR2));
  endfunction

endpackage

// File: rtl/led_pattern_ch.sv
// ---------------------------------------------------------------------------
// led_pattern_ch
// One LED pattern engine. Walks through PAT_W pattern steps, holding each
// step for (time + 1) clock cycles, and drives the LED from the pattern bit
// of the current step through a register (LED lags the step by one cycle).
// Ports:
//   Clk      in  1       system clock
//   Reset    in  1       asynchronous, active-high reset
//   load     in  1       load time/pattern, restart counter and step at 0
//   time_in  in  TIME_W  step time minus 1, in clock cycles
//   pat_in   in  PAT_W   on/off pattern, bit k drives step k
//   led      out 1       LED output
// ---------------------------------------------------------------------------
module led_pattern_ch #(
  parameter int TIME_W       = 32,
  parameter int PAT_W        = 8,
  parameter int DEFAULT_TIME = 24_999_999
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              load,
  input  logic [TIME_W-1:0] time_in,
  input  logic [PAT_W-1:0]  pat_in,
  output logic              led
);

  localparam int                STEP_W    = (PAT_W > 1) ? $clog2(PAT_W) : 1;
  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(PAT_W - 1);

  logic [TIME_W-1:0] r_time;
  logic [PAT_W-1:0]  r_pat;
  logic [TIME_W-1:0] r_cnt;
  logic [STEP_W-1:0] r_step;
  logic              r_led;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_time <= TIME_W'(DEFAULT_TIME);
      r_pat  <= '0;
      r_cnt  <= '0;
      r_step <= '0;
      r_led  <= 1'b0;
    end else begin
      r_led <= r_pat[r_step];
      if (load) begin
        r_time <= time_in;
        r_pat  <= pat_in;
        r_cnt  <= '0;
        r_step <= '0;
      end else if (r_cnt == r_time) begin
        r_cnt  <= '0;
        r_step <= (r_step == STEP_LAST) ? '0 : r_step + STEP_W'(1);
      end else begin
        r_cnt <= r_cnt + TIME_W'(1);
      end
    end
  end

  assign led = r_led;

endmodule

// File: rtl/uart_multi_led_ctrl.sv
// ---------------------------------------------------------------------------
// uart_multi_led_ctrl
// Parses framed commands from the UART byte receiver and drives CH_NUM
// independent LED pattern engines (led_pattern_ch).
// Frame (big-endian): 55 A5 CH T3 T2 T1 T0 PAT [CSUM] F0
// Build option:
//   UART_LED_CHECKSUM_EN  when defined, a CSUM byte (XOR of CH..PAT) sits
//                         before the trailer; a mismatch discards the frame
//                         when the trailer arrives.
// Ports:
//   Clk        in  1       system clock
//   Reset      in  1       asynchronous, active-high reset
//   rx_data    in  8       received byte, valid with rx_done
//   rx_done    in  1       one-cycle strobe per received byte
//   led        out CH_NUM  LED outputs, bit i = channel i
//   cmd_ok     out 1       one-cycle pulse: frame accepted, channel updated
//   frame_err  out 1       one-cycle pulse: frame discarded
//
// Parser states:
//   state  | meaning
//   IDLE   | waiting for first header byte 0x55
//   HDR2   | waiting for 0xA5 (0x55 keeps waiting, anything else drops)
//   CH     | next byte is the channel index
//   T3..T0 | next byte is step-time byte 3 (MSB) .. byte 0
//   PAT    | next byte is the pattern
//   CSUM   | next byte is the checksum (checksum build only)
//   TAIL   | next byte must be 0xF0; frame accepted or rejected here
// ---------------------------------------------------------------------------
module uart_multi_led_ctrl
  import uart_led_pkg::*;
#(
  parameter int CH_NUM       = 4,
  parameter int TIME_W       = 32,
  parameter int PAT_W        = 8,
  parameter int DEFAULT_TIME = 24_999_999,
  parameter int TIMEOUT_CYC  = 5_000_000
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic [7:0]        rx_data,
  input  logic              rx_done,
  output logic [CH_NUM-1:0] led,
  output logic              cmd_ok,
  output logic              frame_err
);

  localparam int               IDLE_W    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_CYC - 1);
  localparam logic [8:0]        CH_LIMIT  = 9'(CH_NUM);

  parser_state_t     r_state;
  parser_state_t     w_next;
  logic [7:0]        r_ch;
  logic [31:0]       r_time;
  logic [7:0]        r_pat;
  logic [IDLE_W-1:0] r_idle_cnt;
  logic              r_cmd_ok;
  logic              r_frame_err;

  logic              w_in_body;
  logic              w_timeout;
  logic              w_accept;
  logic              w_reject;
  logic              w_ch_ok;
  logic              w_csum_ok;
  logic [CH_NUM-1:0] w_load;
  logic [TIME_W-1:0] w_time_in;

  assign w_in_body = in_frame_body(r_state);
  // A byte arriving in the very cycle the limit is hit still counts as in time.
  assign w_timeout = w_in_body && !rx_done && (r_idle_cnt == IDLE_LAST);
  assign w_ch_ok   = ({1'b0, r_ch} < CH_LIMIT);
  assign w_time_in = r_time[TIME_W-1:0];

`ifdef UART_LED_CHECKSUM_EN
  // Running XOR over CH..PAT and the CSUM byte itself: zero means the
  // checksum matched.
  logic [7:0] r_xor;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_xor <= '0;
    end else if (rx_done) begin
      if (r_state == S_HDR2) begin
        r_xor <= '0;
      end else if (w_in_body && (r_state != S_TAIL)) begin
        r_xor <= r_xor ^ rx_data;
      end
    end
  end

  assign w_csum_ok = (r_xor == 8'h00);
`else
  assign w_csum_ok = 1'b1;
`endif

  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    w_reject = 1'b0;
    if (rx_done) begin
      unique case (r_state)
        S_IDLE: if (rx_data == HDR1) w_next = S_HDR2;
        S_HDR2: begin
          if (rx_data == HDR2)      w_next = S_CH;
          else if (rx_data == HDR1) w_next = S_HDR2;
          else                      w_next = S_IDLE;
        end
        S_CH:   w_next = S_T3;
        S_T3:   w_next = S_T2;
        S_T2:   w_next = S_T1;
        S_T1:   w_next = S_T0;
        S_T0:   w_next = S_PAT;
`ifdef UART_LED_CHECKSUM_EN
        S_PAT:  w_next = S_CSUM;
`else
        S_PAT:  w_next = S_TAIL;
`endif
        S_CSUM: w_next = S_TAIL;
        S_TAIL: begin
          w_next = S_IDLE;
          if ((rx_data == TAIL) && w_ch_ok && w_csum_ok) w_accept = 1'b1;
          else                                            w_reject = 1'b1;
        end
        default: w_next = S_IDLE;
      endcase
    end else if (w_timeout) begin
      w_next = S_IDLE;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state     <= S_IDLE;
      r_ch        <= '0;
      r_time      <= '0;
      r_pat       <= '0;
      r_idle_cnt  <= '0;
      r_cmd_ok    <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_cmd_ok    <= w_accept;
      r_frame_err <= w_reject || w_timeout;

      if (rx_done || !w_in_body || w_timeout) r_idle_cnt <= '0;
      else                                     r_idle_cnt <= r_idle_cnt + IDLE_W'(1);

      if (rx_done) begin
        case (r_state)
          S_CH:                   r_ch   <= rx_data;
          S_T3, S_T2, S_T1, S_T0: r_time <= {r_time[23:0], rx_data};
          S_PAT:                  r_pat  <= rx_data;
          default: ;
        endcase
      end
    end
  end

  // The load strobe is taken from the trailer cycle itself so the target
  // channel is updated on the same edge that raises cmd_ok.
  for (genvar g = 0; g < CH_NUM; g++) begin : g_ch
    assign w_load[g] = w_accept && ({1'b0, r_ch} == 9'(g));

    led_pattern_ch #(
      .TIME_W      (TIME_W),
      .PAT_W       (PAT_W),
      .DEFAULT_TIME(DEFAULT_TIME)
    ) u_ch (
      .Clk    (Clk),
      .Reset  (Reset),
      .load   (w_load[g]),
      .time_in(w_time_in),
      .pat_in (r_pat),
      .led    (led[g])
    );
  end

  assign cmd_ok    = r_cmd_ok;
  assign frame_err = r_frame_err;

endmodule
